// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result bus between operand source, alu_seq and result sink
//
// Purpose: groups the input handshake, operands, function select and the
// registered result/flag outputs of alu_seq into one bundle.
// Signals:
//   in_valid  source -> alu   operation presented this cycle
//   in_ready  alu -> source   alu can accept an operation
//   A, B      source -> alu   operands (WIDTH bits)
//   F         source -> alu   3-bit function select
//   Y, Y_hi   alu -> sink     result low / high half
//   out_valid alu -> sink     one-cycle pulse, results updated
//   flag_z/c/v/n alu -> sink  zero, carry/borrow, overflow, negative
// Modports: master = operand source / result sink side, slave = alu_seq.

interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       F;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Y_hi;
  logic             out_valid;
  logic             flag_z;
  logic             flag_c;
  logic             flag_v;
  logic             flag_n;

  modport master (
    output in_valid, A, B, F,
    input  in_ready, Y, Y_hi, out_valid, flag_z, flag_c, flag_v, flag_n
  );

  modport slave (
    input  in_valid, A, B, F,
    output in_ready, Y, Y_hi, out_valid, flag_z, flag_c, flag_v, flag_n
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered WIDTH-bit ALU with flags and shift-add multiply
//
// Purpose: single-cycle logic/add/sub/slt ops plus a WIDTH-cycle unsigned
// shift-add multiply on F = 3'b011, behind a valid/ready input handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    alu_seq_if.slave: in_valid/in_ready, A, B, F in;
//          Y, Y_hi, out_valid, flag_z/c/v/n out (all registered)

module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_seq_if.slave  bus
);
  localparam int MSB = WIDTH - 1;
  localparam int CW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;

  logic accept;
  logic last_step;

  assign accept       = bus.in_valid && (state == IDLE);
  assign last_step    = (state == MUL) && (cnt == LAST);
  assign bus.in_ready = (state == IDLE);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && bus.F == 3'b011) state_next = MUL;
      MUL:     if (cnt == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Single-cycle ALU; add/sub are done one bit wider to expose carry/borrow.
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;
  logic             alu_v;

  assign sum_ext  = {1'b0, bus.A} + {1'b0, bus.B};
  assign diff_ext = {1'b0, bus.A} - {1'b0, bus.B};

  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (bus.F)
      3'b000: alu_y = bus.A & bus.B;
      3'b001: alu_y = bus.A | bus.B;
      3'b010: begin
        alu_y = sum_ext[MSB:0];
        alu_c = sum_ext[WIDTH];
        alu_v = (bus.A[MSB] == bus.B[MSB]) && (sum_ext[MSB] != bus.A[MSB]);
      end
      3'b100: alu_y = bus.A & ~bus.B;
      3'b101: alu_y = bus.A | ~bus.B;
      3'b110: begin
        alu_y = diff_ext[MSB:0];
        alu_c = diff_ext[WIDTH];
        alu_v = (bus.A[MSB] != bus.B[MSB]) && (diff_ext[MSB] != bus.A[MSB]);
      end
      3'b111: begin
        // unsigned A < B is exactly the borrow of A - B
        alu_y = {{(WIDTH-1){1'b0}}, diff_ext[WIDTH]};
        alu_c = diff_ext[WIDTH];
      end
      default: alu_y = '0;
    endcase
  end

  // One shift-add step: prod holds {partial sum, remaining multiplier bits};
  // the add keeps its carry so the shift does not lose the top bit.
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_next;

  assign step_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_next = {step_sum, prod[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand         <= '0;
      prod          <= '0;
      cnt           <= '0;
      bus.Y         <= '0;
      bus.Y_hi      <= '0;
      bus.out_valid <= 1'b0;
      bus.flag_z    <= 1'b0;
      bus.flag_c    <= 1'b0;
      bus.flag_v    <= 1'b0;
      bus.flag_n    <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (accept) begin
        if (bus.F == 3'b011) begin
          mcand <= bus.A;
          prod  <= {{WIDTH{1'b0}}, bus.B};
          cnt   <= '0;
        end else begin
          bus.Y         <= alu_y;
          bus.Y_hi      <= '0;
          bus.flag_z    <= (alu_y == '0);
          bus.flag_c    <= alu_c;
          bus.flag_v    <= alu_v;
          bus.flag_n    <= alu_y[MSB];
          bus.out_valid <= 1'b1;
        end
      end
      if (state == MUL) begin
        prod <= prod_next;
        cnt  <= cnt + 1'b1;
      end
      // The final step's product is loaded directly so that DONE presents it.
      if (last_step) begin
        bus.Y         <= prod_next[WIDTH-1:0];
        bus.Y_hi      <= prod_next[2*WIDTH-1:WIDTH];
        bus.flag_z    <= (prod_next == '0);
        bus.flag_c    <= 1'b0;
        bus.flag_v    <= 1'b0;
        bus.flag_n    <= prod_next[2*WIDTH-1];
        bus.out_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at WIDTH=8 and WIDTH=4

module tb_alu_seq;
  logic clk;
  logic rst_n;

  alu_seq_if #(.WIDTH(8)) if8 ();
  alu_seq_if #(.WIDTH(4)) if4 ();

  alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  alu_seq #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  typedef struct {
    logic [7:0] y;
    logic [7:0] y_hi;
    logic       z, c, v, n;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   ov8    = 0;
  int   ov4    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic [7:0] y, logic [7:0] yh, logic z, logic c, logic v, logic n);
    exp_t e;
    e.y = y; e.y_hi = yh; e.z = z; e.c = c; e.v = v; e.n = n;
    return e;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitors: pop the oldest expectation whenever a result is presented.
  always @(negedge clk) begin
    if (if8.out_valid === 1'b1) begin
      exp_t e;
      ov8++;
      if (q8.size() == 0) begin
        chk("unexpected_out_valid8", 16'd1, 16'd0);
      end else begin
        e = q8.pop_front();
        chk("result8", {if8.Y_hi, if8.Y}, {e.y_hi, e.y});
        chk("flags8", {12'd0, if8.flag_z, if8.flag_c, if8.flag_v, if8.flag_n},
            {12'd0, e.z, e.c, e.v, e.n});
      end
    end
  end

  always @(negedge clk) begin
    if (if4.out_valid === 1'b1) begin
      exp_t e;
      ov4++;
      if (q4.size() == 0) begin
        chk("unexpected_out_valid4", 16'd1, 16'd0);
      end else begin
        e = q4.pop_front();
        chk("result4", {8'd0, if4.Y_hi, if4.Y}, {8'd0, e.y_hi[3:0], e.y[3:0]});
        chk("flags4", {12'd0, if4.flag_z, if4.flag_c, if4.flag_v, if4.flag_n},
            {12'd0, e.z, e.c, e.v, e.n});
      end
    end
  end

  task automatic issue8(input logic [2:0] f, input logic [7:0] a, input logic [7:0] b,
                        input logic push, input exp_t e);
    int t = 0;
    while (if8.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("in_ready8_timeout", 16'd0, 16'd1);
    if8.in_valid = 1'b1; if8.F = f; if8.A = a; if8.B = b;
    @(posedge clk);
    if (push) q8.push_back(e);
    #1 if8.in_valid = 1'b0;
  endtask

  task automatic issue4(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b, input exp_t e);
    int t = 0;
    while (if4.in_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("in_ready4_timeout", 16'd0, 16'd1);
    if4.in_valid = 1'b1; if4.F = f; if4.A = a; if4.B = b;
    @(posedge clk);
    q4.push_back(e);
    #1 if4.in_valid = 1'b0;
  endtask

  task automatic chk_reset8(input string tag);
    chk({tag, "_y"}, {if8.Y_hi, if8.Y}, 16'd0);
    chk({tag, "_flags_ov"}, {11'd0, if8.out_valid, if8.flag_z, if8.flag_c, if8.flag_v, if8.flag_n}, 16'd0);
    chk({tag, "_in_ready"}, {15'd0, if8.in_ready}, 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int low, first, ov_before;
    exp_t none;
    none = mk(0, 0, 0, 0, 0, 0);
    if8.in_valid = 1'b0; if8.F = '0; if8.A = '0; if8.B = '0;
    if4.in_valid = 1'b0; if4.F = '0; if4.A = '0; if4.B = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset8("por");
    chk("por_in_ready4", {15'd0, if4.in_ready}, 16'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: overflow add, then asynchronous mid-cycle reset clears outputs
    issue8(3'b010, 8'h7F, 8'h01, 1'b1, mk(8'h80, 8'h00, 0, 0, 1, 1));
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset8("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue8(3'b010, 8'h7F, 8'h01, 1'b1, mk(8'h80, 8'h00, 0, 0, 1, 1));

    // 2: carry then borrow, back-to-back
    issue8(3'b010, 8'hFF, 8'h01, 1'b1, mk(8'h00, 8'h00, 1, 1, 0, 0));
    chk("b2b_ov_first", {15'd0, if8.out_valid}, 16'd1);
    issue8(3'b110, 8'h03, 8'h05, 1'b1, mk(8'hFE, 8'h00, 0, 1, 0, 1));
    chk("b2b_ov_second", {15'd0, if8.out_valid}, 16'd1);
    chk("b2b_in_ready", {15'd0, if8.in_ready}, 16'd1);
    repeat (2) @(negedge clk);

    // 3: logic / SLT sweep at WIDTH=4
    issue4(3'b000, 4'hC, 4'hA, mk(8'h08, 8'h00, 0, 0, 0, 1));
    issue4(3'b100, 4'hC, 4'hA, mk(8'h04, 8'h00, 0, 0, 0, 0));
    issue4(3'b101, 4'hC, 4'hA, mk(8'h0D, 8'h00, 0, 0, 0, 1));
    issue4(3'b111, 4'h2, 4'h9, mk(8'h01, 8'h00, 0, 1, 0, 0));
    repeat (2) @(negedge clk);

    // 4: max*max, busy time and latency
    issue8(3'b011, 8'hFF, 8'hFF, 1'b1, mk(8'h01, 8'hFE, 0, 0, 0, 1));
    low = 0; first = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (if8.in_ready === 1'b0) low++;
      if (if8.out_valid === 1'b1 && first == 0) first = k;
    end
    chk("mul_busy_cycles", 16'(low), 16'd9);
    chk("mul_latency", 16'(first), 16'd9);

    // 5: add requests while multiplying are ignored
    ov_before = ov8;
    issue8(3'b011, 8'd12, 8'd10, 1'b1, mk(8'd120, 8'h00, 0, 0, 0, 0));
    if8.in_valid = 1'b1; if8.F = 3'b010; if8.A = 8'h01; if8.B = 8'h01;
    first = 0;
    for (int k = 0; k < 30 && first == 0; k++) begin
      @(negedge clk);
      if (if8.out_valid === 1'b1) first = 1;
    end
    if8.in_valid = 1'b0;
    chk("busy_mul_done_seen", 16'(first), 16'd1);
    repeat (5) @(negedge clk);
    chk("busy_single_out_valid", 16'(ov8 - ov_before), 16'd1);

    // 6: reset four cycles into a multiply discards it
    issue8(3'b011, 8'h33, 8'h44, 1'b0, none);
    ov_before = ov8;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset8("mul_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("mul_rst_no_out_valid", 16'(ov8 - ov_before), 16'd0);
    issue8(3'b011, 8'h00, 8'h55, 1'b1, mk(8'h00, 8'h00, 1, 0, 0, 0));
    repeat (12) @(negedge clk);

    chk("sb8_drained", 16'(q8.size()), 16'd0);
    chk("sb4_drained", 16'(q4.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor of the team's 4-bit combinational ALU.
- Keeps the same 3-bit function encoding, generalised to WIDTH bits.
- Adds status flags, a valid/ready input handshake and a multi-cycle shift-add unsigned multiply on the previously unused code 3'b011.
- Sits between an operand source (register file / switches) and a result sink (display / accumulator).

Parameters:
WIDTH, 8, operand and result width in bits (>= 2)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and function presented this cycle
in_ready  output  1  block can accept an operation (high only in IDLE)
A  input  WIDTH  operand A, unsigned / two's complement
B  input  WIDTH  operand B
F  input  3  function select
Y  output  WIDTH  result (low half for multiply)
Y_hi  output  WIDTH  high half of product; 0 for all other ops
out_valid  output  1  one-cycle pulse: Y, Y_hi and flags updated
flag_z  output  1  Y == 0 (multiply: full 2*WIDTH product == 0)
flag_c  output  1  carry (add) / borrow (sub, slt); 0 otherwise
flag_v  output  1  signed overflow (add, sub); 0 otherwise
flag_n  output  1  Y[WIDTH-1]; multiply: Y_hi[WIDTH-1]

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0 except in_ready = 1.
  - FSM returns to IDLE; any in-flight multiply is discarded with no out_valid.
- Function codes (A, B captured at accept):
  - 000 A&B
  - 001 A|B
  - 010 A+B
  - 011 A*B unsigned, 2*WIDTH result
  - 100 A&~B
  - 101 A|~B
  - 110 A-B
  - 111 SLT: Y = 1 if A < B unsigned, else 0
- Accept: an operation is taken on a rising edge where in_valid && in_ready. in_valid while in_ready = 0 is ignored (not queued).
- Single-cycle ops (every code except 011):
  - Result and flags registered on the accept edge.
  - out_valid high for the following cycle only.
  - in_ready stays 1, so back-to-back accepts give back-to-back out_valid.
- Multiply (011):
  - FSM IDLE -> MUL on accept; in_ready drops to 0 the next cycle.
  - MUL runs exactly WIDTH cycles of shift-add: test multiplier LSB, conditionally add multiplicand into the upper half, shift right.
  - After the last MUL cycle, FSM goes to DONE for 1 cycle: {Y_hi, Y} loaded, flags set, out_valid = 1, in_ready = 0.
  - DONE -> IDLE.
  - Accept-to-out_valid latency is WIDTH+1 cycles; a new accept is possible on the DONE edge+1.
- Flags:
  - Add: flag_c = carry out of bit WIDTH-1; flag_v = (A[msb]==B[msb]) && (Y[msb]!=A[msb]).
  - Sub: flag_c = 1 when A < B unsigned (borrow); flag_v = (A[msb]!=B[msb]) && (Y[msb]!=A[msb]).
  - Logic ops: c = v = 0.
  - SLT: c = borrow, v = 0.
- Hold: Y, Y_hi and flags hold their last value between out_valid pulses.
- Wrap-around: add/sub results are modulo 2^WIDTH.
- Multiply edge cases: either operand 0 -> product 0, flag_z = 1. Max*max -> {Y_hi, Y} = (2^WIDTH-1)^2 exactly.

Test Plan (WIDTH=8 unless stated):
1. Reset: rst_n low mid-cycle -> all outputs 0 and in_ready = 1 asynchronously. Release, then accept F=010 A=8'h7F B=8'h01 -> next cycle out_valid = 1, Y = 8'h80, flag_v = 1, flag_n = 1, flag_c = 0.
2. Add carry / sub borrow back-to-back:
   - F=010 A=8'hFF B=8'h01 -> Y = 0, flag_c = 1, flag_z = 1.
   - Next cycle F=110 A=8'h03 B=8'h05 -> Y = 8'hFE, flag_c = 1, flag_n = 1.
   - out_valid high on two consecutive cycles.
3. Logic / SLT sweep, WIDTH=4:
   - F=000 A=4'hC B=4'hA -> Y = 4'h8.
   - F=100 same operands -> 4'h4.
   - F=101 -> 4'hD.
   - F=111 A=2 B=9 -> Y = 1, flag_c = 1.
4. Multiply: F=011 A=8'hFF B=8'hFF -> in_ready low for 9 cycles; out_valid exactly 9 cycles after accept; Y_hi = 8'hFE, Y = 8'h01, flag_n = 1.
5. Busy ignore: during the multiply A=8'd12 B=8'd10, assert in_valid with F=010 each cycle -> only one out_valid; Y = 8'd120, Y_hi = 0. The add is never executed.
6. Reset mid-multiply: rst_n low 4 cycles into MUL -> no out_valid and outputs 0. After release, accept F=011 A=0 B=8'h55 -> product 0, flag_z = 1.
